// File: rtl/gradient_abs.sv
// Gradient conditioning for the HOG pipeline: saturated |gx|, |gy| and the
// upper-half orientation flag, behind a registered output with a one-entry skid buffer.
module gradient_abs #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH:0]   data_in1,
    input  logic [DATA_WIDTH:0]   data_in2,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] data_out1,
    output logic [DATA_WIDTH-1:0] data_out2,
    output logic                  is_upper_bin
);

    localparam int unsigned PW = 2 * DATA_WIDTH + 1;

    function automatic logic [DATA_WIDTH-1:0] sat_abs(input logic [DATA_WIDTH:0] x);
        logic [DATA_WIDTH:0] neg;
        neg = '0 - x;
        if (!x[DATA_WIDTH])
            return x[DATA_WIDTH-1:0];
        // Negating the most negative value wraps back to itself, so its sign stays set
        else if (neg[DATA_WIDTH])
            return '1;
        else
            return neg[DATA_WIDTH-1:0];
    endfunction

    logic          accept;
    logic          nz1, nz2, sgn1, sgn2, upper;
    logic [PW-1:0] in_payload;

    logic          out_valid_q, out_valid_d;
    logic [PW-1:0] out_payload_q, out_payload_d;
    logic          skid_valid_q, skid_valid_d;
    logic [PW-1:0] skid_payload_q, skid_payload_d;
    logic          in_ready_q;

    assign accept = in_valid && in_ready_q;

    assign nz1   = |data_in1;
    assign nz2   = |data_in2;
    assign sgn1  = data_in1[DATA_WIDTH];
    assign sgn2  = data_in2[DATA_WIDTH];
    assign upper = (sgn1 && nz2 && !sgn2) || (nz1 && !sgn1 && sgn2);

    assign in_payload = {upper, sat_abs(data_in2), sat_abs(data_in1)};

    always_comb begin
        out_valid_d    = out_valid_q;
        out_payload_d  = out_payload_q;
        skid_valid_d   = skid_valid_q;
        skid_payload_d = skid_payload_q;
        if (!out_valid_q || out_ready) begin
            // Skid entry is older than anything on the input, so it drains first
            if (skid_valid_q) begin
                out_payload_d = skid_payload_q;
                out_valid_d   = 1'b1;
                skid_valid_d  = 1'b0;
            end else if (accept) begin
                out_payload_d = in_payload;
                out_valid_d   = 1'b1;
            end else begin
                out_valid_d   = 1'b0;
            end
        end else if (accept) begin
            skid_payload_d = in_payload;
            skid_valid_d   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q    <= 1'b0;
            out_payload_q  <= '0;
            skid_valid_q   <= 1'b0;
            skid_payload_q <= '0;
            in_ready_q     <= 1'b1;
        end else begin
            out_valid_q    <= out_valid_d;
            out_payload_q  <= out_payload_d;
            skid_valid_q   <= skid_valid_d;
            skid_payload_q <= skid_payload_d;
            in_ready_q     <= !skid_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign {is_upper_bin, data_out2, data_out1} = out_payload_q;

endmodule

// File: tb/tb_gradient_abs.sv
// Directed and scoreboard-checked bench for gradient_abs.
module tb_gradient_abs;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW:0]   data_in1;
    logic [DW:0]   data_in2;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] data_out1;
    logic [DW-1:0] data_out2;
    logic          is_upper_bin;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    gradient_abs #(.DATA_WIDTH(DW)) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .data_in1(data_in1),
        .data_in2(data_in2),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .data_out1(data_out1),
        .data_out2(data_out2),
        .is_upper_bin(is_upper_bin)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Reference: integer arithmetic, then clamp; result packed as {|gx|, |gy|, upper}
    function automatic logic [16:0] model_out(input logic [8:0] x, input logic [8:0] y);
        int vx, vy, ax, ay;
        logic up;
        vx = $signed(x);
        vy = $signed(y);
        ax = (vx < 0) ? -vx : vx;
        ay = (vy < 0) ? -vy : vy;
        if (ax > 255) ax = 255;
        if (ay > 255) ay = 255;
        up = ((vx < 0) && (vy > 0)) || ((vx > 0) && (vy < 0));
        return {ax[7:0], ay[7:0], up};
    endfunction

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        data_in1 = 9'd5; data_in2 = 9'h1F9;
        step; step;
        checks++;
        if ({out_valid, data_out1, data_out2, is_upper_bin} !== 18'd0)
            $display("FAIL reset_outputs: got %h expected %h",
                     {out_valid, data_out1, data_out2, is_upper_bin}, 18'd0);
        else passes++;
        checks++;
        if (in_ready !== 1'b1)
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        else passes++;
        rst = 1'b0; in_valid = 1'b0;
        step;
        checks++;
        if ({out_valid, in_ready} !== 2'b01)
            $display("FAIL post_reset_idle: got %b expected 01", {out_valid, in_ready});
        else passes++;
    endtask

    task automatic test_basic_and_bounds;
        int gx[8] = '{5, -7, 12, -1, -256, 0, 255, -256};
        int gy[8] = '{-3, -9, 4, 200, 255, -128, 0, -256};
        int e1[8] = '{5, 7, 12, 1, 255, 0, 255, 255};
        int e2[8] = '{3, 9, 4, 200, 255, 128, 0, 255};
        int eu[8] = '{1, 0, 0, 1, 1, 0, 0, 0};
        logic [17:0] exp_v;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            data_in1 = 9'(gx[i]);
            data_in2 = 9'(gy[i]);
            in_valid = 1'b1;
            step;
            in_valid = 1'b0;
            exp_v = {1'b1, 8'(e1[i]), 8'(e2[i]), 1'(eu[i])};
            checks++;
            if ({out_valid, data_out1, data_out2, is_upper_bin} !== exp_v)
                $display("FAIL vector_%0d (gx=%0d gy=%0d): got %h expected %h", i, gx[i], gy[i],
                         {out_valid, data_out1, data_out2, is_upper_bin}, exp_v);
            else passes++;
            step;
            checks++;
            if (out_valid !== 1'b0)
                $display("FAIL vector_%0d_drop: out_valid got %b expected 0", i, out_valid);
            else passes++;
        end
    endtask

    task automatic test_back_to_back;
        logic [8:0]  a, b;
        logic [18:0] exp_v;
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            a = 9'($urandom_range(0, 511));
            b = 9'($urandom_range(0, 511));
            data_in1 = a; data_in2 = b; in_valid = 1'b1;
            step;
            exp_v = {2'b11, model_out(a, b)};
            checks++;
            if ({out_valid, in_ready, data_out1, data_out2, is_upper_bin} !== exp_v)
                $display("FAIL stream_%0d: got %h expected %h", i,
                         {out_valid, in_ready, data_out1, data_out2, is_upper_bin}, exp_v);
            else passes++;
        end
        in_valid = 1'b0;
        step;
    endtask

    task automatic test_backpressure;
        logic [16:0] q[$];
        logic [16:0] held;
        logic [8:0]  cx, cy;
        logic        pre_acc, pre_drain, pre_stall;
        int          sent = 0, got = 0;
        cx = 9'($urandom_range(0, 511));
        cy = 9'($urandom_range(0, 511));
        for (int cyc = 0; cyc < 90; cyc++) begin
            out_ready = (cyc >= 70) ? 1'b1 : 1'($urandom_range(0, 1));
            in_valid  = (cyc < 70) && (sent < 45);
            data_in1  = cx;
            data_in2  = cy;
            pre_acc   = in_valid && in_ready;
            pre_drain = out_valid && out_ready;
            pre_stall = out_valid && !out_ready;
            held      = {data_out1, data_out2, is_upper_bin};
            if (pre_drain) begin
                checks++;
                if (q.size() == 0)
                    $display("FAIL bp_spurious_output: got %h expected none", held);
                else if (held !== q[0])
                    $display("FAIL bp_order: got %h expected %h", held, q[0]);
                else passes++;
                if (q.size() != 0) void'(q.pop_front());
                got++;
            end
            if (pre_acc) begin
                q.push_back(model_out(cx, cy));
                sent++;
                cx = 9'($urandom_range(0, 511));
                cy = 9'($urandom_range(0, 511));
            end
            step;
            checks++;
            if ({out_valid, in_ready} !== {q.size() > 0, q.size() < 2})
                $display("FAIL bp_flags_cyc%0d: got %b expected %b", cyc,
                         {out_valid, in_ready}, {q.size() > 0, q.size() < 2});
            else passes++;
            if (pre_stall) begin
                checks++;
                if ({data_out1, data_out2, is_upper_bin} !== held)
                    $display("FAIL bp_hold_cyc%0d: got %h expected %h", cyc,
                             {data_out1, data_out2, is_upper_bin}, held);
                else passes++;
            end
        end
        checks++;
        if ((got !== sent) || (q.size() != 0))
            $display("FAIL bp_count: got %0d outputs expected %0d", got, sent);
        else passes++;
        in_valid = 1'b0;
    endtask

    task automatic test_reset_midstream;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        data_in1 = 9'd100; data_in2 = 9'h1F0;
        step;
        data_in1 = 9'h1C0; data_in2 = 9'd33;
        step;
        in_valid = 1'b0;
        checks++;
        if ({out_valid, in_ready} !== 2'b10)
            $display("FAIL mid_full: got %b expected 10", {out_valid, in_ready});
        else passes++;
        rst = 1'b1;
        step;
        rst = 1'b0;
        checks++;
        if ({out_valid, in_ready} !== 2'b01)
            $display("FAIL mid_reset: got %b expected 01", {out_valid, in_ready});
        else passes++;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step;
            checks++;
            if ({out_valid, in_ready} !== 2'b01)
                $display("FAIL mid_stale_%0d: got %b expected 01", i, {out_valid, in_ready});
            else passes++;
        end
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        data_in1 = '0; data_in2 = '0;
        test_reset;
        test_basic_and_bounds;
        test_back_to_back;
        test_backpressure;
        test_reset_midstream;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/gradient_abs.md
Name: gradient_abs

Overview:
Per-pixel gradient conditioning stage of the HOG pipeline. Takes a signed horizontal/vertical gradient pair, produces their unsigned magnitudes, and flags whether the gradient angle lies in the upper half (90°–180°) of the unsigned orientation range. It sits between the gradient (Sobel/difference) stage and the magnitude/bin-vote stage. Streaming, with valid/ready handshake and a 1-cycle registered latency.

Parameters:
DATA_WIDTH, 8, magnitude width; inputs are DATA_WIDTH+1 bits two's complement, outputs DATA_WIDTH bits unsigned.

Ports:
clk  in  1  single clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  input pair valid
in_ready  out  1  block can accept input this cycle
data_in1  in  DATA_WIDTH+1  signed gradient gx (two's complement)
data_in2  in  DATA_WIDTH+1  signed gradient gy (two's complement)
out_valid  out  1  output pair valid
out_ready  in  1  downstream accepts output this cycle
data_out1  out  DATA_WIDTH  |gx|, saturated
data_out2  out  DATA_WIDTH  |gy|, saturated
is_upper_bin  out  1  1 = gx, gy strictly opposite signs (angle in 90°–180°)

Behaviour:
- Reset (rst=1 at clk edge): out_valid=0, data_out1=0, data_out2=0, is_upper_bin=0, internal skid buffer empty, in_ready=1 from the cycle after reset. Reset mid-transfer discards all held data.
- Input transfer: in_valid & in_ready at clk edge. Output transfer: out_valid & out_ready at clk edge.
- Latency: accepted pair appears on outputs with out_valid=1 the next cycle.
- Throughput: one pair per cycle when out_ready=1. Implement as output register plus one-entry skid buffer; in_ready is registered (= skid buffer empty), with no combinational path from out_ready to in_ready.
- Backpressure: while out_valid=1 & out_ready=0, outputs are held stable; one further in-flight pair is captured in the skid buffer, then in_ready=0. When the output drains, the skid entry moves to the output register first (order preserved, no loss, no duplication).
- Absolute value: x >= 0 -> x[DATA_WIDTH-1:0]; x < 0 -> -x. The single unrepresentable case x = -2^DATA_WIDTH (-256 for default) saturates to 2^DATA_WIDTH-1 (255).
- is_upper_bin = 1 iff (data_in1 < 0 and data_in2 > 0) or (data_in1 > 0 and data_in2 < 0). Either input zero -> 0. Both same sign -> 0.
- All three outputs are computed from the same accepted pair and registered together.
- Outputs are don't-care-stable when out_valid=0 (hold last value).

Test Plan:
- Reset: assert rst 2 cycles with in_valid=1 -> out_valid=0, outputs 0, in_ready=1 after release.
- Basic signs: (gx,gy)=(5,-3) -> 5,3,upper=1; (-7,-9) -> 7,9,upper=0; (12,4) -> 12,4,upper=0; (-1,200) -> 1,200,upper=1; each one cycle after acceptance.
- Boundaries: (-256,255) -> 255,255,upper=1; (0,-128) -> 0,128,upper=0; (255,0) -> 255,0,upper=0; (-256,-256) -> 255,255,upper=0.
- Streaming: 20 random 9-bit pairs back-to-back with out_ready=1 -> 20 outputs on consecutive cycles, matching a golden model in order.
- Backpressure: stream with out_ready toggled pseudo-randomly -> in_ready drops after exactly one extra accept while stalled, held outputs stable, no loss or duplication, order preserved.
- Reset mid-stream: rst asserted with both output and skid register full -> next cycle out_valid=0, in_ready=1, stale data never emitted.
